// File: rtl/aes_bcd_pkg.sv
// Shared types and constants for the BCD-to-binary converter.
package aes_bcd_pkg;

    localparam int unsigned DIGIT_W = 4;

    localparam logic [DIGIT_W-1:0] BCD_MAX_DIGIT = 4'd9;
    localparam logic [DIGIT_W-1:0] BCD_CORR      = 4'd3;
    localparam logic [DIGIT_W-1:0] BCD_CORR_THR  = 4'd8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } bcd2bin_state_t;

    // Error flags reported alongside a result.
    typedef struct packed {
        logic digit;
        logic range;
    } bcd2bin_err_t;

    function automatic logic bcd_digit_bad(input logic [DIGIT_W-1:0] digit);
        return digit > BCD_MAX_DIGIT;
    endfunction

endpackage

// File: rtl/bcd_digit_corr.sv
// One BCD digit of the reverse double-dabble step: subtract 3 when the digit is >= 8.
module bcd_digit_corr
    import aes_bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] digit,
    output logic [DIGIT_W-1:0] corr_c
);

    always_comb begin
        corr_c = digit;
        if (digit >= BCD_CORR_THR) begin
            corr_c = digit - BCD_CORR;
        end
    end

endmodule

// File: rtl/bcd_to_bin_seq.sv
// Sequential BCD-to-binary converter (reverse double-dabble, one bit per clock).
// Optional digit/range checking is enabled by defining BCD2BIN_ERR_EN.
module bcd_to_bin_seq
    import aes_bcd_pkg::*;
#(
    parameter int unsigned DIGITS = 3,
    parameter int unsigned BIN_W  = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DIGIT_W*DIGITS-1:0] bcd_in,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [BIN_W-1:0]          bin_out,
    output logic                      err_digit,
    output logic                      err_range
);

    localparam int unsigned BCD_W  = DIGIT_W * DIGITS;
    localparam int unsigned PAIR_W = BCD_W + BIN_W;
    localparam int unsigned CNT_W  = (BIN_W > 1) ? $clog2(BIN_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

    bcd2bin_state_t     state, state_n;
    logic [BCD_W-1:0]   bcd_reg, bcd_n;
    logic [BIN_W-1:0]   bin_reg, bin_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic               in_ready_n;
    logic               out_valid_n;
    logic [BIN_W-1:0]   bin_out_n;
    bcd2bin_err_t       err_q, err_n;

    logic [PAIR_W-1:0]  pair_shift_c;
    logic [BCD_W-1:0]   bcd_shift_c;
    logic [BIN_W-1:0]   bin_shift_c;
    logic [BCD_W-1:0]   bcd_corr_c;

    assign err_digit = err_q.digit;
    assign err_range = err_q.range;

    // One right shift of the combined work register per cycle.
    assign pair_shift_c = {bcd_reg, bin_reg} >> 1;
    assign bcd_shift_c  = pair_shift_c[PAIR_W-1:BIN_W];
    assign bin_shift_c  = pair_shift_c[BIN_W-1:0];

    for (genvar g = 0; g < int'(DIGITS); g++) begin : g_corr
        bcd_digit_corr u_corr (
            .digit  (bcd_shift_c[g*DIGIT_W +: DIGIT_W]),
            .corr_c (bcd_corr_c[g*DIGIT_W +: DIGIT_W])
        );
    end

`ifdef BCD2BIN_ERR_EN
    logic digit_bad_c;

    always_comb begin
        digit_bad_c = 1'b0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            digit_bad_c = digit_bad_c | bcd_digit_bad(bcd_in[i*DIGIT_W +: DIGIT_W]);
        end
    end
`endif

    // Next-state and next-output logic.
    always_comb begin
        state_n     = state;
        bcd_n       = bcd_reg;
        bin_n       = bin_reg;
        cnt_n       = cnt;
        out_valid_n = out_valid;
        bin_out_n   = bin_out;
        err_n       = err_q;

        case (state)
            IDLE: begin
                if (in_valid) begin
                    bcd_n   = bcd_in;
                    bin_n   = '0;
                    cnt_n   = '0;
                    state_n = SHIFT;
`ifdef BCD2BIN_ERR_EN
                    if (digit_bad_c) begin
                        state_n     = DONE;
                        out_valid_n = 1'b1;
                        bin_out_n   = '0;
                        err_n.digit = 1'b1;
                        err_n.range = 1'b0;
                    end
`endif
                end
            end

            SHIFT: begin
                bcd_n = bcd_corr_c;
                bin_n = bin_shift_c;
                cnt_n = cnt + CNT_W'(1);
                if (cnt == CNT_LAST) begin
                    state_n     = DONE;
                    out_valid_n = 1'b1;
                    bin_out_n   = bin_shift_c;
                    err_n.digit = 1'b0;
`ifdef BCD2BIN_ERR_EN
                    // Anything left in the BCD part is the quotient by 2^BIN_W.
                    err_n.range = |bcd_corr_c;
`else
                    err_n.range = 1'b0;
`endif
                end
            end

            DONE: begin
                if (out_ready) begin
                    state_n     = IDLE;
                    out_valid_n = 1'b0;
                    err_n       = '0;
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase

        in_ready_n = (state_n == IDLE);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Work and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcd_reg   <= '0;
            bin_reg   <= '0;
            cnt       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            bin_out   <= '0;
            err_q     <= '0;
        end else begin
            bcd_reg   <= bcd_n;
            bin_reg   <= bin_n;
            cnt       <= cnt_n;
            in_ready  <= in_ready_n;
            out_valid <= out_valid_n;
            bin_out   <= bin_out_n;
            err_q     <= err_n;
        end
    end

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Self-checking bench for bcd_to_bin_seq against an arithmetic decimal reference model.
module tb_bcd_to_bin_seq;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] bcd_in;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  bin_out;
    logic        err_digit;
    logic        err_range;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int accept_cyc = 0;

    bcd_to_bin_seq #(.DIGITS(3), .BIN_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .bcd_in    (bcd_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .bin_out   (bin_out),
        .err_digit (err_digit),
        .err_range (err_range)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Decimal value of the word; result, flags and latency follow from it.
    function automatic void model(input logic [11:0] bcd, output logic [7:0] eb,
                                  output logic ed, output logic er,
                                  output bit bad, output int lat);
        int v;
        int w;
        logic [3:0] d;
        v = 0;
        w = 1;
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            d = bcd[4*i +: 4];
            if (d > 4'd9) bad = 1;
            v = v + int'(d) * w;
            w = w * 10;
        end
`ifdef BCD2BIN_ERR_EN
        if (bad) begin
            eb = 8'h00; ed = 1'b1; er = 1'b0; lat = 0;
        end else begin
            eb = 8'(v % 256); ed = 1'b0; er = (v > 255); lat = 8;
        end
`else
        eb = 8'(v % 256); ed = 1'b0; er = 1'b0; lat = 8;
`endif
    endfunction

    function automatic logic [11:0] rand_legal();
        logic [11:0] b;
        for (int i = 0; i < 3; i++) b[4*i +: 4] = 4'($urandom_range(0, 9));
        return b;
    endfunction

    task automatic apply_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        bcd_in = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Drives one word, checks busy period, latency, held result and handshake.
    task automatic convert(input logic [11:0] bcd, input int hold, input bit noise);
        logic [7:0] eb;
        logic ed, er;
        bit bad, chk_bin;
        int lat, n;
        model(bcd, eb, ed, er, bad, lat);
        chk_bin = !bad;
`ifdef BCD2BIN_ERR_EN
        chk_bin = 1;
`endif
        in_valid = 1'b1;
        bcd_in = bcd;
        @(posedge clk);
        #1;
        accept_cyc = cyc;
        in_valid = noise ? 1'($urandom) : 1'b0;
        if (noise) bcd_in = 12'($urandom);
        n = 0;
        while (!out_valid && n < 40) begin
            checks++;
            if (in_ready !== 1'b0) begin
                failures++;
                $display("FAIL busy_in_ready bcd=%h cycle=%0d got=%b exp=0", bcd, n, in_ready);
            end
            @(posedge clk);
            #1;
            if (noise) begin
                in_valid = 1'($urandom);
                bcd_in = 12'($urandom);
            end
            n++;
        end
        checks++;
        if (out_valid !== 1'b1) begin
            failures++;
            $display("FAIL timeout bcd=%h got out_valid=%b exp=1", bcd, out_valid);
            apply_reset();
            return;
        end
        checks++;
        if (n !== lat) begin
            failures++;
            $display("FAIL latency bcd=%h got=%0d exp=%0d", bcd, n, lat);
        end
        for (int h = 0; h <= hold; h++) begin
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || (chk_bin && bin_out !== eb)
                || err_digit !== ed || err_range !== er) begin
                failures++;
                $display("FAIL done_hold bcd=%h h=%0d got v=%b rdy=%b bin=%h ed=%b er=%b exp v=1 rdy=0 bin=%h ed=%b er=%b",
                         bcd, h, out_valid, in_ready, bin_out, err_digit, err_range, eb, ed, er);
            end
            if (h < hold) begin
                @(posedge clk);
                #1;
                if (noise) begin
                    in_valid = 1'($urandom);
                    bcd_in = 12'($urandom);
                end
            end
        end
        out_ready = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || err_digit !== 1'b0 || err_range !== 1'b0) begin
            failures++;
            $display("FAIL handshake bcd=%h got v=%b rdy=%b ed=%b er=%b exp v=0 rdy=1 ed=0 er=0",
                     bcd, out_valid, in_ready, err_digit, err_range);
        end
    endtask

    task automatic check_reset_values(input string tag);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || bin_out !== 8'h00
            || err_digit !== 1'b0 || err_range !== 1'b0) begin
            failures++;
            $display("FAIL %s got rdy=%b v=%b bin=%h ed=%b er=%b exp rdy=1 v=0 bin=00 ed=0 er=0",
                     tag, in_ready, out_valid, bin_out, err_digit, err_range);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        bcd_in = '0;
        #12;
        check_reset_values("reset_asserted");
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_reset_values("reset_released");
    endtask

    task automatic test_directed();
        convert(12'h255, 0, 0);
        convert(12'h256, 0, 0);
        convert(12'h999, 0, 0);
        convert(12'h000, 0, 0);
        convert(12'h1A3, 0, 0);
        convert(12'h001, 0, 0);
    endtask

    task automatic test_hold();
        convert(12'h200, 5, 0);
        convert(12'h731, 5, 1);
    endtask

    task automatic test_back_to_back();
        int c0;
        convert(12'h128, 0, 0);
        c0 = accept_cyc;
        convert(12'h000, 0, 0);
        checks++;
        if (accept_cyc - c0 !== 10) begin
            failures++;
            $display("FAIL throughput got=%0d exp=10", accept_cyc - c0);
        end
    endtask

    task automatic test_random();
        logic [11:0] b;
        for (int k = 0; k < 60; k++) begin
            b = rand_legal();
            if ($urandom_range(0, 4) == 0) b[4*$urandom_range(0, 2) +: 4] = 4'($urandom_range(10, 15));
            convert(b, int'($urandom_range(0, 3)), 1'($urandom));
        end
    endtask

    task automatic test_reset_mid_shift();
        convert(12'h123, 0, 0);
        in_valid = 1'b1;
        bcd_in = 12'h245;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check_reset_values("reset_mid_shift");
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check_reset_values("discarded_shift");
        convert(12'h187, 0, 0);
    endtask

    task automatic test_reset_in_done();
        in_valid = 1'b1;
        bcd_in = 12'h099;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b1 || bin_out !== 8'h63) begin
            failures++;
            $display("FAIL pre_reset_done got v=%b bin=%h exp v=1 bin=63", out_valid, bin_out);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check_reset_values("reset_in_done");
        @(posedge clk);
        #1 rst_n = 1'b1;
        convert(12'h042, 0, 0);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_hold();
        test_back_to_back();
        test_random();
        test_reset_mid_shift();
        test_reset_in_done();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "global timeout");
    end

endmodule
